pll40_core: RTL and testbench
=============================

PLL40_CORE -- requirements
Module: pll40_core

Interface
REQ-001 SHALL have parameter DIVR, default 0, 4-bit reference divider (divide by DIVR+1).
REQ-002 SHALL have parameter DIVF, default 0, 7-bit feedback multiplier (multiply by DIVF+1).
REQ-003 SHALL have parameter DIVQ, default 0, 3-bit output divider (divide by 2^DIVQ); valid range 0..6, 7 treated as 6.
REQ-004 SHALL have parameter PLLOUT_SELECT, default "GENCLK", output mode: "GENCLK" or "GENCLK_HALF"; any other value behaves as "GENCLK".
REQ-005 SHALL have parameter ENABLE_ICEGATE, default 1'b0, which enables output freeze.
REQ-006 SHALL accept parameters FILTER_RANGE, FEEDBACK_PATH, DELAY_ADJUSTMENT_MODE_FEEDBACK, DELAY_ADJUSTMENT_MODE_RELATIVE, FDA_FEEDBACK, FDA_RELATIVE and SHIFTREG_DIV_MODE, all without functional effect.
REQ-007 CLK  input  1  single timebase clock; all logic on its rising edge.
REQ-008 RESET  input  1  synchronous, active-high reset.
REQ-009 REFERENCECLK  input  1  reference clock, treated as an asynchronous data signal sampled by CLK.
REQ-010 BYPASS  input  1  1 = outputs follow the synchronized reference.
REQ-011 LATCHINPUTVALUE  input  1  1 with ENABLE_ICEGATE=1 = freeze outputs.
REQ-012 PLLOUTCORE  output  1  synthesized clock.
REQ-013 PLLOUTGLOBAL  output  1  identical copy of PLLOUTCORE.
REQ-014 LOCK  output  1  frequency lock indicator.

Function
REQ-015 REFERENCECLK SHALL pass through a 2-flop synchronizer; a rising edge is detected when the second flop is 1 and a third delay flop is 0.
REQ-016 A 16-bit period counter SHALL increment each CLK, saturate at 0xFFFF, and on each detected edge latch its value+1 into PERIOD and restart at 0.
REQ-017 The first detected edge after reset SHALL only start counting; PERIOD becomes valid at the second edge.
REQ-018 On each edge with valid PERIOD: if |new-old| <= 1, a 3-bit match counter SHALL increment (saturating at 4); otherwise it SHALL clear.
REQ-019 LOCK SHALL be 1 while match counter = 4; it SHALL clear on a mismatch or when the period counter saturates (lost reference), and the match counter and PERIOD-valid flag SHALL then clear.
REQ-020 The synthesizer SHALL be a 25-bit accumulator: each CLK add INC = 2*(DIVF+1); when the result >= TH = PERIOD*(DIVR+1)*2^DIVQ, subtract TH and toggle the internal clock.
REQ-021 There SHALL be at most one toggle per CLK; if INC >= TH, the internal clock SHALL toggle every CLK (CLK/2 saturation).
REQ-022 Resulting frequency SHALL be f_ref*(DIVF+1)/((DIVR+1)*2^DIVQ), averaged over the accumulator cycle.
REQ-023 The synthesizer SHALL hold the accumulator at 0 and the internal clock at 0 while PERIOD is invalid; it runs regardless of LOCK.
REQ-024 In "GENCLK_HALF" mode, the output SHALL toggle on every second internal toggle.
REQ-025 PLLOUTCORE SHALL be registered (1 CLK after the toggle decision).
REQ-026 BYPASS=1 SHALL make PLLOUTCORE equal to the second synchronizer flop, registered, with measurement and LOCK logic unaffected.
REQ-027 ENABLE_ICEGATE=1 and LATCHINPUTVALUE=1 SHALL hold PLLOUTCORE and PLLOUTGLOBAL at their current value; the accumulator keeps running.
REQ-028 A change of PERIOD SHALL not reset the accumulator; if the accumulator >= the new TH, it SHALL subtract TH on the next CLK.

Reset
REQ-029 RESET=1 at a CLK edge SHALL clear synchronizer flops, the period counter, PERIOD (0, invalid), the match counter, the accumulator, the internal/half clocks, PLLOUTCORE, PLLOUTGLOBAL and LOCK to 0.
REQ-030 Reset asserted mid-operation SHALL take priority over all other updates, and lock acquisition SHALL restart from the first edge after release.

Verification
REQ-031 Defaults, ref period 64 CLK (32 high/32 low) -> PERIOD=64; LOCK rises 1 CLK after the 6th detected edge.
REQ-032 DIVR=0, DIVF=19, DIVQ=4, ref period 64 -> TH=1024, INC=40; output averages 5 periods per 4 reference periods (51.2 CLK), toggle spacing 25 or 26 CLK.
REQ-033 Locked, then hold REFERENCECLK low -> LOCK falls when the period counter reaches 0xFFFF, and the output stops at 0.
REQ-034 Ref period changes 64->80 while locked -> LOCK drops at the first 80-period edge and returns after 4 matching periods; the output period scales to 64 CLK.
REQ-035 BYPASS=1 -> PLLOUTCORE equals REFERENCECLK delayed 3 CLK, and LOCK behaves as in REQ-031.
REQ-036 GENCLK_HALF with DIVF=1, ref period 64 -> output period 64 CLK; a RESET pulse mid-run gives all outputs 0 on the next CLK.

Source files
------------

// File: rtl/pll40_core.sv
// pll40_core: clock synthesizer built entirely on the CLK timebase.
// The reference clock is synchronized and its period measured in CLK cycles.
// A phase accumulator then derives an output clock of
// f_ref*(DIVF+1)/((DIVR+1)*2^DIVQ) from that measurement.
module pll40_core #(
  parameter logic [3:0] DIVR                           = 4'd0,
  parameter logic [6:0] DIVF                           = 7'd0,
  parameter logic [2:0] DIVQ                           = 3'd0,
  parameter string      PLLOUT_SELECT                  = "GENCLK",
  parameter logic       ENABLE_ICEGATE                 = 1'b0,
  parameter logic [2:0] FILTER_RANGE                   = 3'd0,
  parameter string      FEEDBACK_PATH                  = "SIMPLE",
  parameter string      DELAY_ADJUSTMENT_MODE_FEEDBACK = "FIXED",
  parameter string      DELAY_ADJUSTMENT_MODE_RELATIVE = "FIXED",
  parameter logic [3:0] FDA_FEEDBACK                   = 4'd0,
  parameter logic [3:0] FDA_RELATIVE                   = 4'd0,
  parameter logic [1:0] SHIFTREG_DIV_MODE              = 2'd0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic REFERENCECLK,
  input  logic BYPASS,
  input  logic LATCHINPUTVALUE,
  output logic PLLOUTCORE,
  output logic PLLOUTGLOBAL,
  output logic LOCK
);

  // DIVQ=7 is folded onto 6; the output divider tops out at 2^6.
  localparam int unsigned DIVQ_E = (DIVQ == 3'd7) ? 32'd6 : {29'd0, DIVQ};
  // Any select value other than GENCLK_HALF falls back to GENCLK.
  localparam bit HALF_MODE = (PLLOUT_SELECT == "GENCLK_HALF");
  // Accumulator step is 2*(DIVF+1): two toggles per output period.
  localparam logic [8:0]  INC     = {1'b0, DIVF, 1'b0} + 9'd2;
  localparam logic [4:0]  RDIV    = {1'b0, DIVR} + 5'd1;
  localparam logic [24:0] ACC_MAX = '1;
  localparam logic [2:0]  MATCH_LOCK = 3'd4;

  // Analog-only configuration knobs; they have no effect in this model.
  logic unused_cfg;
  assign unused_cfg = ^{FILTER_RANGE, FDA_FEEDBACK, FDA_RELATIVE, SHIFTREG_DIV_MODE,
                        (FEEDBACK_PATH == "SIMPLE"),
                        (DELAY_ADJUSTMENT_MODE_FEEDBACK == "FIXED"),
                        (DELAY_ADJUSTMENT_MODE_RELATIVE == "FIXED")};

  // Synchronizer and edge-detect delay flop.
  logic sync1_q, sync2_q, sync3_q;
  logic ref_rise;

  // Period measurement and lock state.
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] period_q, period_d;
  logic [15:0] meas;
  logic        seen_q, seen_d;
  logic        pvld_q, pvld_d;
  logic [2:0]  match_q, match_d;
  logic        lock_q, lock_d;
  logic        cnt_sat;
  logic        close;

  // Synthesizer state.
  logic [24:0] acc_q, acc_d;
  logic [26:0] th_w;
  logic [24:0] th;
  logic [25:0] sum;
  logic        tgl;
  logic        iclk_q, iclk_d;
  logic        half_q, half_d;

  // Output stage.
  logic out_q, out_d;
  logic glob_q;

  assign ref_rise = sync2_q & ~sync3_q;
  assign cnt_sat  = (cnt_q == 16'hFFFF);

  // Measure the reference period and track how many consecutive periods agree.
  always_comb begin
    cnt_d    = cnt_sat ? cnt_q : cnt_q + 16'd1;
    period_d = period_q;
    seen_d   = seen_q;
    pvld_d   = pvld_q;
    match_d  = match_q;
    meas     = cnt_q + 16'd1;
    close    = ({1'b0, meas} <= {1'b0, period_q} + 17'd1) &&
               ({1'b0, period_q} <= {1'b0, meas} + 17'd1);
    if (ref_rise) begin
      cnt_d = '0;
      if (!seen_q || cnt_sat) begin
        // First edge (or first edge after a lost reference) only starts the count.
        seen_d  = 1'b1;
        pvld_d  = 1'b0;
        match_d = '0;
      end else begin
        period_d = meas;
        pvld_d   = 1'b1;
        if (pvld_q) begin
          if (close) match_d = (match_q == MATCH_LOCK) ? MATCH_LOCK : match_q + 3'd1;
          else       match_d = '0;
        end
      end
    end else if (cnt_sat) begin
      // Reference lost: drop everything and wait for a fresh first edge.
      seen_d  = 1'b0;
      pvld_d  = 1'b0;
      match_d = '0;
    end
    lock_d = (match_d == MATCH_LOCK);
  end

  // Phase accumulator: at most one toggle per CLK, CLK/2 when the step exceeds the threshold.
  always_comb begin
    // Threshold clamps to the accumulator range so the sum can never wrap.
    th_w   = (27'(period_q) * 27'(RDIV)) << DIVQ_E;
    th     = (th_w > 27'(ACC_MAX)) ? ACC_MAX : th_w[24:0];
    sum    = 26'(acc_q) + 26'(INC);
    tgl    = 1'b0;
    acc_d  = acc_q;
    iclk_d = iclk_q;
    half_d = half_q;
    if (!pvld_q) begin
      acc_d  = '0;
      iclk_d = 1'b0;
      half_d = 1'b0;
    end else begin
      if (26'(INC) >= 26'(th)) begin
        tgl   = 1'b1;
        acc_d = '0;
      end else if (sum >= 26'(th)) begin
        tgl   = 1'b1;
        acc_d = 25'(sum - 26'(th));
      end else begin
        acc_d = 25'(sum);
      end
      iclk_d = iclk_q ^ tgl;
      // Half clock flips on the falling internal toggle, i.e. every second toggle.
      half_d = half_q ^ (tgl & iclk_q);
    end
  end

  // Output select: bypass, synthesized clock, or frozen value.
  always_comb begin
    if (BYPASS)         out_d = sync2_q;
    else if (HALF_MODE) out_d = half_d;
    else                out_d = iclk_d;
    if (ENABLE_ICEGATE && LATCHINPUTVALUE) out_d = out_q;
  end

  // All state updates; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      seen_q   <= 1'b0;
      pvld_q   <= 1'b0;
      match_q  <= '0;
      lock_q   <= 1'b0;
      acc_q    <= '0;
      iclk_q   <= 1'b0;
      half_q   <= 1'b0;
      out_q    <= 1'b0;
      glob_q   <= 1'b0;
    end else begin
      sync1_q  <= REFERENCECLK;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      seen_q   <= seen_d;
      pvld_q   <= pvld_d;
      match_q  <= match_d;
      lock_q   <= lock_d;
      acc_q    <= acc_d;
      iclk_q   <= iclk_d;
      half_q   <= half_d;
      out_q    <= out_d;
      glob_q   <= out_d;
    end
  end

  assign PLLOUTCORE   = out_q;
  assign PLLOUTGLOBAL = glob_q;
  assign LOCK         = lock_q;

endmodule

// File: tb/tb_pll40_core.sv
// tb_pll40_core: scoreboard bench for pll40_core, three configurations on shared stimulus.
`timescale 1ns/1ps
module tb_pll40_core;
  logic clk = 1'b0, rst = 1'b0, refclk = 1'b0, byp = 1'b0, latch = 1'b0;
  logic d_core, d_glob, d_lock, s_core, s_glob, s_lock, h_core, h_glob, h_lock;

  always #5 clk = ~clk;

  pll40_core u_def (
    .CLK(clk), .RESET(rst), .REFERENCECLK(refclk), .BYPASS(byp), .LATCHINPUTVALUE(latch),
    .PLLOUTCORE(d_core), .PLLOUTGLOBAL(d_glob), .LOCK(d_lock));

  pll40_core #(.DIVR(4'd0), .DIVF(7'd19), .DIVQ(3'd4)) u_syn (
    .CLK(clk), .RESET(rst), .REFERENCECLK(refclk), .BYPASS(byp), .LATCHINPUTVALUE(latch),
    .PLLOUTCORE(s_core), .PLLOUTGLOBAL(s_glob), .LOCK(s_lock));

  pll40_core #(.DIVF(7'd1), .PLLOUT_SELECT("GENCLK_HALF"), .ENABLE_ICEGATE(1'b1)) u_half (
    .CLK(clk), .RESET(rst), .REFERENCECLK(refclk), .BYPASS(byp), .LATCHINPUTVALUE(latch),
    .PLLOUTCORE(h_core), .PLLOUTGLOBAL(h_glob), .LOCK(h_lock));

  int checks = 0, errors = 0;
  int cyc = 0;
  int d_last = 0, s_last = 0, h_last = 0;
  logic d_prev, s_prev, h_prev;
  int d_gaps[$], s_gaps[$], h_gaps[$];
  logic byp_q[$];
  bit exp_lock_q[$];
  bit byp_on = 1'b0;
  bit lk_trace[0:255];
  bit m_seen, m_pvld;
  int m_per, m_last, m_match;

  // Output transition monitor: spacing between output edges in CLK cycles.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (d_core !== d_prev) begin d_gaps.push_back(cyc - d_last); d_last = cyc; end
    if (s_core !== s_prev) begin s_gaps.push_back(cyc - s_last); s_last = cyc; end
    if (h_core !== h_prev) begin h_gaps.push_back(cyc - h_last); h_last = cyc; end
    d_prev = d_core;
    s_prev = s_core;
    h_prev = h_core;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_seen = 1'b0; m_pvld = 1'b0; m_per = 0; m_last = 0; m_match = 0;
    exp_lock_q.delete();
    byp_q.delete();
  endtask

  task automatic do_reset();
    refclk = 1'b0; rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    model_reset();
  endtask

  // One reference period starting with a rising edge; pushes expected LOCK for this period.
  task automatic drive_period(input int per);
    if (!m_seen) m_seen = 1'b1;
    else if (!m_pvld) begin m_per = m_last; m_pvld = 1'b1; end
    else begin
      if ((m_last - m_per <= 1) && (m_per - m_last <= 1)) m_match = (m_match >= 4) ? 4 : m_match + 1;
      else m_match = 0;
      m_per = m_last;
    end
    m_last = per;
    exp_lock_q.push_back(m_match == 4);
    for (int c = 0; c < per; c++) begin
      refclk = (c < per / 2);
      if (byp_on) byp_q.push_back(refclk);
      step();
      lk_trace[c] = d_lock;
      if (byp_on && byp_q.size() == 3) begin
        logic e;
        e = byp_q.pop_front();
        checks++;
        if (d_core !== e) begin
          errors++;
          $display("FAIL bypass cyc %0d: got %b expected %b", cyc, d_core, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    byp = 1'b0; latch = 1'b0; refclk = 1'b0; rst = 1'b1;
    repeat (3) step();
    checks += 9;
    if ({d_core, d_glob, d_lock} !== 3'b000) begin errors++; $display("FAIL reset_def: got %b expected 000", {d_core, d_glob, d_lock}); end
    if ({s_core, s_glob, s_lock} !== 3'b000) begin errors++; $display("FAIL reset_syn: got %b expected 000", {s_core, s_glob, s_lock}); end
    if ({h_core, h_glob, h_lock} !== 3'b000) begin errors++; $display("FAIL reset_half: got %b expected 000", {h_core, h_glob, h_lock}); end
    if (d_core !== 1'b0) begin errors++; $display("FAIL reset_core: got %b expected 0", d_core); end
    if (d_glob !== 1'b0) begin errors++; $display("FAIL reset_glob: got %b expected 0", d_glob); end
    if (d_lock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b expected 0", d_lock); end
    if (s_core !== 1'b0) begin errors++; $display("FAIL reset_syn_core: got %b expected 0", s_core); end
    if (h_core !== 1'b0) begin errors++; $display("FAIL reset_half_core: got %b expected 0", h_core); end
    if (h_glob !== 1'b0) begin errors++; $display("FAIL reset_half_glob: got %b expected 0", h_glob); end
    rst = 1'b0;
    repeat (4) step();
    checks += 2;
    if (d_lock !== 1'b0) begin errors++; $display("FAIL idle_lock: got %b expected 0", d_lock); end
    if (d_core !== 1'b0) begin errors++; $display("FAIL idle_core: got %b expected 0", d_core); end
    model_reset();
  endtask

  task automatic test_lock();
    bit e;
    for (int p = 1; p <= 8; p++) begin
      drive_period(64);
      e = exp_lock_q.pop_front();
      checks++;
      if (d_lock !== e) begin errors++; $display("FAIL lock_p%0d: got %b expected %b", p, d_lock, e); end
      if (p == 6) begin
        checks += 2;
        if (lk_trace[1] !== 1'b0) begin errors++; $display("FAIL lock_early: got %b expected 0", lk_trace[1]); end
        if (lk_trace[2] !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b expected 1", lk_trace[2]); end
      end
      if (p == 4) d_gaps.delete();
    end
    checks++;
    if (d_gaps.size() < 4) begin errors++; $display("FAIL def_gap_count: got %0d expected >=4", d_gaps.size()); end
    foreach (d_gaps[i]) begin
      checks++;
      if (d_gaps[i] != 32) begin errors++; $display("FAIL def_gap64: got %0d expected 32", d_gaps[i]); end
    end
  endtask

  task automatic test_synth();
    bit e;
    int sum;
    s_gaps.delete();
    for (int p = 1; p <= 8; p++) begin
      drive_period(64);
      e = exp_lock_q.pop_front();
      checks++;
      if (s_lock !== e) begin errors++; $display("FAIL synth_lock_p%0d: got %b expected %b", p, s_lock, e); end
    end
    checks++;
    if (s_gaps.size() < 18) begin errors++; $display("FAIL synth_gap_count: got %0d expected >=18", s_gaps.size()); end
    foreach (s_gaps[i]) begin
      checks++;
      if (s_gaps[i] != 25 && s_gaps[i] != 26) begin errors++; $display("FAIL synth_gap: got %0d expected 25 or 26", s_gaps[i]); end
    end
    for (int i = 0; i + 10 <= s_gaps.size(); i++) begin
      sum = 0;
      for (int k = 0; k < 10; k++) sum += s_gaps[i + k];
      checks++;
      if (sum != 256) begin errors++; $display("FAIL synth_window: got %0d expected 256", sum); end
    end
  endtask

  task automatic test_period_change();
    bit e;
    for (int p = 1; p <= 8; p++) begin
      drive_period(80);
      e = exp_lock_q.pop_front();
      checks++;
      if (d_lock !== e) begin errors++; $display("FAIL pchg_lock_p%0d: got %b expected %b", p, d_lock, e); end
      if (p == 3) begin d_gaps.delete(); s_gaps.delete(); end
    end
    checks += 2;
    if (d_gaps.size() < 6) begin errors++; $display("FAIL pchg_def_count: got %0d expected >=6", d_gaps.size()); end
    if (s_gaps.size() < 8) begin errors++; $display("FAIL pchg_syn_count: got %0d expected >=8", s_gaps.size()); end
    foreach (d_gaps[i]) begin
      checks++;
      if (d_gaps[i] != 40) begin errors++; $display("FAIL pchg_def_gap: got %0d expected 40", d_gaps[i]); end
    end
    foreach (s_gaps[i]) begin
      checks++;
      if (s_gaps[i] != 32) begin errors++; $display("FAIL pchg_syn_gap: got %0d expected 32", s_gaps[i]); end
    end
  endtask

  task automatic test_bypass();
    bit e;
    do_reset();
    byp = 1'b1;
    byp_on = 1'b1;
    for (int p = 1; p <= 7; p++) begin
      drive_period(64);
      e = exp_lock_q.pop_front();
      checks++;
      if (d_lock !== e) begin errors++; $display("FAIL byp_lock_p%0d: got %b expected %b", p, d_lock, e); end
    end
    byp_on = 1'b0;
    byp = 1'b0;
    byp_q.delete();
  endtask

  task automatic test_lost_ref();
    bit e;
    drive_period(64);
    e = exp_lock_q.pop_front();
    checks++;
    if (d_lock !== e) begin errors++; $display("FAIL lost_pre_lock: got %b expected %b", d_lock, e); end
    refclk = 1'b0;
    for (int j = 1; j <= 65600; j++) begin
      step();
      if (64 + j == 65530) begin
        checks++;
        if (d_lock !== 1'b1) begin errors++; $display("FAIL lost_lock_hold: got %b expected 1", d_lock); end
      end
      if (64 + j == 65550) begin
        checks++;
        if (d_lock !== 1'b0) begin errors++; $display("FAIL lost_lock_drop: got %b expected 0", d_lock); end
      end
      if (64 + j == 65560) begin d_gaps.delete(); s_gaps.delete(); end
    end
    checks += 4;
    if (d_core !== 1'b0) begin errors++; $display("FAIL lost_def_core: got %b expected 0", d_core); end
    if (s_core !== 1'b0) begin errors++; $display("FAIL lost_syn_core: got %b expected 0", s_core); end
    if (d_gaps.size() != 0) begin errors++; $display("FAIL lost_def_quiet: got %0d edges expected 0", d_gaps.size()); end
    if (s_gaps.size() != 0) begin errors++; $display("FAIL lost_syn_quiet: got %0d edges expected 0", s_gaps.size()); end
    model_reset();
  endtask

  task automatic test_half();
    bit e;
    do_reset();
    for (int p = 1; p <= 8; p++) begin
      drive_period(64);
      e = exp_lock_q.pop_front();
      checks++;
      if (h_lock !== e) begin errors++; $display("FAIL half_lock_p%0d: got %b expected %b", p, h_lock, e); end
      if (p == 3) h_gaps.delete();
    end
    checks++;
    if (h_gaps.size() < 6) begin errors++; $display("FAIL half_gap_count: got %0d expected >=6", h_gaps.size()); end
    foreach (h_gaps[i]) begin
      checks++;
      if (h_gaps[i] != 32) begin errors++; $display("FAIL half_gap: got %0d expected 32", h_gaps[i]); end
    end
    // Freeze the gated instance; the ungated one keeps running.
    latch = 1'b1;
    step();
    h_gaps.delete(); d_gaps.delete();
    for (int p = 0; p < 2; p++) begin drive_period(64); e = exp_lock_q.pop_front(); end
    checks += 2;
    if (h_gaps.size() != 0) begin errors++; $display("FAIL icegate_frozen: got %0d edges expected 0", h_gaps.size()); end
    if (d_gaps.size() < 2) begin errors++; $display("FAIL icegate_other_runs: got %0d edges expected >=2", d_gaps.size()); end
    latch = 1'b0;
    h_gaps.delete();
    for (int p = 0; p < 2; p++) begin drive_period(64); e = exp_lock_q.pop_front(); end
    checks++;
    if (h_gaps.size() < 2) begin errors++; $display("FAIL icegate_release: got %0d edges expected >=2", h_gaps.size()); end
    // Reset pulse mid-run: everything low on the next CLK.
    rst = 1'b1;
    step();
    checks += 3;
    if ({d_core, d_glob, d_lock} !== 3'b000) begin errors++; $display("FAIL pulse_def: got %b expected 000", {d_core, d_glob, d_lock}); end
    if ({s_core, s_glob, s_lock} !== 3'b000) begin errors++; $display("FAIL pulse_syn: got %b expected 000", {s_core, s_glob, s_lock}); end
    if ({h_core, h_glob, h_lock} !== 3'b000) begin errors++; $display("FAIL pulse_half: got %b expected 000", {h_core, h_glob, h_lock}); end
    rst = 1'b0;
    step();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_synth();
    test_period_change();
    test_bypass();
    test_lost_ref();
    test_half();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
